// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, byte-enable constants and lane-merge helper
//               for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Lanes with their enable set come from new_w, the rest keep old_w.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] result;
    result = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) result[8*i +: 8] = new_w[8*i +: 8];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester ports and RAM port of the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;

  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_be;
  logic        p0_ack;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_be;
  logic        p1_ack;
  logic [31:0] p1_rdata;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  // Master is the environment: both requesters plus the RAM.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    input  p1_ack, p1_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    output p1_ack, p1_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant with ack masking; only the
//               last-granted pointer is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req,
  input  wire logic [1:0] ack,
  input  wire logic       update,
  output logic            gnt_valid,
  output logic            gnt_id
);

  logic       r_last;
  logic [1:0] w_elig;

  // A port whose ack is high this cycle is still finishing its handshake.
  assign w_elig = req & ~ack;

  always_comb begin
    gnt_valid = |w_elig;
    gnt_id    = 1'b0;
    case (w_elig)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~r_last;
      default: gnt_id = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (update && gnt_valid) begin
      r_last <= gnt_id;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin sharing of a word-wide RAM between two ports,
//               with read-modify-write sequencing for partial-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dmem_arbiter_if.slave bus
);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_id;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [31:0]     r_merge;
  logic [1:0]      r_ack;
  logic [31:0]     r_rdata0;
  logic [31:0]     r_rdata1;

  logic            w_gnt_valid;
  logic            w_gnt_id;
  logic            w_grant;
  logic            w_done;
  logic            w_rd_cap;
  logic            w_merge_en;
  logic            w_sel_we;
  logic [31:0]     w_sel_addr;
  logic [31:0]     w_sel_wdata;
  logic [3:0]      w_sel_be;
  logic            w_unused;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.p1_req, bus.p0_req}),
    .ack       (r_ack),
    .update    (r_state == IDLE),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_grant     = (r_state == IDLE) && w_gnt_valid;
  assign w_sel_we    = w_gnt_id ? bus.p1_we    : bus.p0_we;
  assign w_sel_addr  = w_gnt_id ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_gnt_id ? bus.p1_wdata : bus.p0_wdata;
  assign w_sel_be    = w_gnt_id ? bus.p1_be    : bus.p0_be;

  // Byte-offset and high address bits are dropped, so addresses wrap.
  assign w_unused = ^{bus.p0_addr[31:AW+2], bus.p0_addr[1:0],
                      bus.p1_addr[31:AW+2], bus.p1_addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_rd_cap     = 1'b0;
    w_merge_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) w_state_next = ACCESS;
      end
      ACCESS: begin
        if (!r_we) begin
          w_rd_cap     = 1'b1;
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else if ((r_be == BE_FULL) || (r_be == BE_NONE)) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_merge_en   = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= 32'h0;
      r_be     <= 4'h0;
      r_merge  <= 32'h0;
      r_ack    <= 2'b00;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_done ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      if (w_grant) begin
        r_id    <= w_gnt_id;
        r_we    <= w_sel_we;
        r_waddr <= w_sel_addr[AW+1:2];
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
      end
      if (w_rd_cap) begin
        if (r_id) r_rdata1 <= bus.mem_dout;
        else      r_rdata0 <= bus.mem_dout;
      end
      if (w_merge_en) begin
        r_merge <= be_merge(bus.mem_dout, r_wdata, r_be);
      end
    end
  end

  // Gating with rst keeps an abandoned partial write from reaching the RAM.
  assign bus.mem_we   = !rst && (((r_state == ACCESS) && r_we && (r_be == BE_FULL))
                                 || (r_state == WRITE));
  assign bus.mem_addr = {{(30-AW){1'b0}}, r_waddr, 2'b00};
  assign bus.mem_din  = (r_state == WRITE) ? r_merge : r_wdata;

  assign bus.p0_ack   = r_ack[0];
  assign bus.p1_ack   = r_ack[1];
  assign bus.p0_rdata = r_rdata0;
  assign bus.p1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] ram [0:255];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = ram[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_we) ram[pl_idx] <= pl_val;
    else if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_din;
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    pl_we = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issue one request, wait for its ack, then leave one idle cycle.
  task automatic xact(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output int lat, output int wes, output logic [31:0] rd);
    lat = 99; wes = 0; rd = 32'h0;
    if (port == 0) begin
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr;
      bus.p0_wdata = wdata; bus.p0_be = be;
    end else begin
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr;
      bus.p1_wdata = wdata; bus.p1_be = be;
    end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.mem_we) wes++;
      if ((port == 0 && bus.p0_ack) || (port == 1 && bus.p1_ack)) begin
        lat = c;
        rd  = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
        break;
      end
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we_during: got %b want 0", bus.mem_we); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.p0_ack, bus.p1_ack} !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b want 00", {bus.p0_ack, bus.p1_ack}); end
    checks++;
    if (bus.p0_rdata !== 32'h0) begin errors++; $display("FAIL rst_p0_rdata: got %h want 0", bus.p0_rdata); end
    checks++;
    if (bus.p1_rdata !== 32'h0) begin errors++; $display("FAIL rst_p1_rdata: got %h want 0", bus.p1_rdata); end
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    checks++;
    if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    checks++;
    if (bus.mem_din !== 32'h0) begin errors++; $display("FAIL rst_mem_din: got %h want 0", bus.mem_din); end
  endtask

  task automatic test_full_write_read;
    int lat, wes;
    logic [31:0] rd;
    xact(0, 1'b1, 32'h20, 32'hCAFEBABE, 4'hF, lat, wes, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL fw_latency: got %0d want 2", lat); end
    checks++;
    if (wes !== 1) begin errors++; $display("FAIL fw_we_cycles: got %0d want 1", wes); end
    checks++;
    if (ram[8] !== 32'hCAFEBABE) begin errors++; $display("FAIL fw_ram: got %h want cafebabe", ram[8]); end
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, wes, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++;
    if (rd !== 32'hCAFEBABE) begin errors++; $display("FAIL rd_data: got %h want cafebabe", rd); end
    checks++;
    if (wes !== 0) begin errors++; $display("FAIL rd_we_cycles: got %0d want 0", wes); end
    checks++;
    if (bus.p0_ack !== 1'b0 || bus.p0_rdata !== 32'hCAFEBABE) begin
      errors++; $display("FAIL rd_hold: got ack=%b data=%h want ack=0 data=cafebabe", bus.p0_ack, bus.p0_rdata);
    end
  endtask

  task automatic test_byte_store;
    int lat, wes;
    logic [31:0] rd;
    xact(1, 1'b1, 32'h20, 32'h0000_0011, 4'b0001, lat, wes, rd);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
    checks++;
    if (wes !== 1) begin errors++; $display("FAIL sb_we_cycles: got %0d want 1", wes); end
    xact(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, wes, rd);
    checks++;
    if (rd !== 32'hCAFEBA11) begin errors++; $display("FAIL sb_read: got %h want cafeba11", rd); end
    xact(1, 1'b1, 32'h20, 32'h5566_0000, 4'b1100, lat, wes, rd);
    checks++;
    if (lat !== 3 || wes !== 1) begin errors++; $display("FAIL sh_timing: got lat=%0d we=%0d want lat=3 we=1", lat, wes); end
    xact(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, wes, rd);
    checks++;
    if (rd !== 32'h5566BA11) begin errors++; $display("FAIL sh_read: got %h want 5566ba11", rd); end
  endtask

  task automatic test_be_zero_wrap;
    int lat, wes;
    logic [31:0] rd;
    poke(8'd16, 32'h12345678);
    xact(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, lat, wes, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL be0_latency: got %0d want 2", lat); end
    checks++;
    if (wes !== 0) begin errors++; $display("FAIL be0_we_cycles: got %0d want 0", wes); end
    checks++;
    if (ram[16] !== 32'h12345678) begin errors++; $display("FAIL be0_ram: got %h want 12345678", ram[16]); end
    xact(1, 1'b1, 32'h420, 32'hA5A5_A5A5, 4'hF, lat, wes, rd);
    checks++;
    if (ram[8] !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_ram: got %h want a5a5a5a5", ram[8]); end
    xact(0, 1'b0, 32'h23, 32'h0, 4'h0, lat, wes, rd);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_read: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_contention;
    int order [6];
    int n;
    int both;
    int exp_id;
    poke(8'd32, 32'h1111_0000);
    poke(8'd33, 32'h2222_0000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; both = 0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h80;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h84;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(posedge clk); #1;
      if (bus.p0_ack && bus.p1_ack) both++;
      if (bus.p0_ack) begin
        order[n] = 0; n++;
        checks++;
        if (bus.p0_rdata !== 32'h1111_0000) begin errors++; $display("FAIL cont_p0_data: got %h want 11110000", bus.p0_rdata); end
      end else if (bus.p1_ack) begin
        order[n] = 1; n++;
        checks++;
        if (bus.p1_rdata !== 32'h2222_0000) begin errors++; $display("FAIL cont_p1_data: got %h want 22220000", bus.p1_rdata); end
      end
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n !== 6) begin errors++; $display("FAIL cont_count: got %0d grants want 6", n); end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL cont_dual_ack: got %0d cycles want 0", both); end
    for (int i = 0; i < n; i++) begin
      exp_id = i % 2;
      checks++;
      if (order[i] !== exp_id) begin errors++; $display("FAIL cont_order[%0d]: got port %0d want %0d", i, order[i], exp_id); end
    end
  endtask

  task automatic test_reset_mid;
    int acks;
    int first;
    acks = 0;
    first = -1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h20;
    bus.p0_wdata = 32'h0000_00FF; bus.p0_be = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rm_in_write: got mem_we=%b want 1", bus.mem_we); end
    rst = 1'b1;
    bus.p0_req = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_gated: got %b want 0", bus.mem_we); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (bus.p0_ack || bus.p1_ack) acks++;
      checks++;
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_after[%0d]: got %b want 0", c, bus.mem_we); end
    end
    rst = 1'b0;
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL rm_no_ack: got %0d acks want 0", acks); end
    checks++;
    if (ram[8] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rm_ram: got %h want a5a5a5a5", ram[8]); end
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h20;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h84;
    for (int c = 0; c < 10 && first < 0; c++) begin
      @(posedge clk); #1;
      if (bus.p0_ack) first = 0;
      else if (bus.p1_ack) first = 1;
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    checks++;
    if (first !== 0) begin errors++; $display("FAIL rm_first_tie: got port %0d want 0", first); end
    checks++;
    if (bus.p0_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rm_read: got %h want a5a5a5a5", bus.p0_rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    pl_we = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0; bus.p0_be = 4'h0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0; bus.p1_be = 4'h0;
    test_reset();
    test_full_write_read();
    test_byte_store();
    test_be_zero_wrap();
    test_contention();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
